// File: rtl/dac_pkg.sv
// Shared definitions for the DAC decoder back end.
//   N_ELEM_DEFAULT : default number of unit elements (thermometer width)
//   MAX_W          : widest thermometer code the helper functions accept
//   mode_e         : per-sample operating mode latched with the sample
//   ptr_width()    : width of the DWA rotation pointer for a given element count
//   popcount()     : number of ones in a (zero-extended) code
//   is_therm()     : true when a code is a legal thermometer code of a given weight
package dac_pkg;

    localparam int unsigned N_ELEM_DEFAULT = 8;
    localparam int unsigned MAX_W          = 64;

    typedef logic [MAX_W-1:0] wide_t;

    typedef enum logic {
        ModeBypass = 1'b0,
        ModeDwa    = 1'b1
    } mode_e;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned popcount(input wide_t v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(MAX_W); i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    // A legal code has exactly its low 'cnt' bits set. At cnt == MAX_W the shift
    // yields zero, and zero minus one is all ones, which is still the right mask.
    function automatic logic is_therm(input wide_t v, input int unsigned cnt);
        wide_t mask;
        mask = (wide_t'(1) << cnt) - wide_t'(1);
        return v == mask;
    endfunction

endpackage

// File: rtl/dwa_scrambler_if.sv
// Sample/element bus between the thermometer decoder, the DWA scrambler and the
// DAC switch drivers.
//   en          : 1 = DWA rotation, 0 = bypass (qualified by therm_valid)
//   therm_valid : therm_in is valid this cycle (no backpressure)
//   therm_in    : thermometer code, ones contiguous from bit 0
//   elem_out    : registered unit-element enables
//   elem_valid  : elem_out updated this cycle
//   ptr_out     : rotation pointer (next start element)
//   therm_err   : the sample now on elem_out was not a legal thermometer code
// master: the side producing codes and consuming element enables.
// slave : the scrambler.
interface dwa_scrambler_if
    import dac_pkg::*;
#(
    parameter int unsigned N_ELEM = N_ELEM_DEFAULT
) ();

    localparam int unsigned PTR_W = ptr_width(N_ELEM);

    logic              en;
    logic              therm_valid;
    logic [N_ELEM-1:0] therm_in;
    logic [N_ELEM-1:0] elem_out;
    logic              elem_valid;
    logic [PTR_W-1:0]  ptr_out;
    logic              therm_err;

    modport master (
        output en,
        output therm_valid,
        output therm_in,
        input  elem_out,
        input  elem_valid,
        input  ptr_out,
        input  therm_err
    );

    modport slave (
        input  en,
        input  therm_valid,
        input  therm_in,
        output elem_out,
        output elem_valid,
        output ptr_out,
        output therm_err
    );

endinterface

// File: rtl/dwa_rotator.sv
// Combinational DWA element selector.
//   count   : number of elements to enable, 0..N_ELEM
//   ptr     : first element to enable
//   mask    : unrotated selection, low 'count' bits set
//   rotated : mask rotated left by ptr, wrapping bit N_ELEM-1 to bit 0
module dwa_rotator
    import dac_pkg::*;
#(
    parameter int unsigned N_ELEM = N_ELEM_DEFAULT
) (
    input  logic [$clog2(N_ELEM+1)-1:0]  count,
    input  logic [ptr_width(N_ELEM)-1:0] ptr,
    output logic [N_ELEM-1:0]            mask,
    output logic [N_ELEM-1:0]            rotated
);

    localparam int unsigned PTR_W = ptr_width(N_ELEM);

    always_comb begin
        mask    = '0;
        rotated = '0;
        for (int i = 0; i < int'(N_ELEM); i++) begin
            mask[i] = (i < int'(count));
        end
        // Element i is fed from mask bit (i - ptr); the PTR_W-bit subtraction
        // gives the modulo-N_ELEM wrap for free since N_ELEM is a power of two.
        for (int i = 0; i < int'(N_ELEM); i++) begin
            rotated[i] = mask[PTR_W'(i) - ptr];
        end
    end

endmodule

// File: rtl/dwa_scrambler.sv
// Data-weighted-averaging scrambler: maps each thermometer sample onto the next
// free unit elements so element mismatch is first-order noise-shaped.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dwa_scrambler_if slave (codes in, element enables/pointer/error out)
// Stage 1 latches popcount, legality and mode of each valid sample; stage 2
// drives elem_out and advances the pointer. Latency two edges, one sample/cycle.
// N_ELEM must match the interface instance and be a power of two, >= 4.
module dwa_scrambler
    import dac_pkg::*;
#(
    parameter int unsigned N_ELEM = N_ELEM_DEFAULT
) (
    input logic          clk,
    input logic          rst_n,
    dwa_scrambler_if.slave bus
);

    localparam int unsigned PTR_W = ptr_width(N_ELEM);
    localparam int unsigned CNT_W = $clog2(N_ELEM + 1);

    // Stage 1 ---------------------------------------------------------------
    wide_t              therm_wide;
    int unsigned        in_ones;
    logic               s1_valid_d, s1_valid_q;
    logic [CNT_W-1:0]   s1_count_d, s1_count_q;
    logic               s1_legal_d, s1_legal_q;
    mode_e              s1_mode_d,  s1_mode_q;

    assign therm_wide = wide_t'(bus.therm_in);
    assign in_ones    = popcount(therm_wide);

    always_comb begin
        s1_valid_d = bus.therm_valid;
        s1_count_d = s1_count_q;
        s1_legal_d = s1_legal_q;
        s1_mode_d  = s1_mode_q;
        if (bus.therm_valid) begin
            // Illegal codes still use their popcount so element usage tracks
            // the number of ones actually presented.
            s1_count_d = CNT_W'(in_ones);
            s1_legal_d = is_therm(therm_wide, in_ones);
            s1_mode_d  = bus.en ? ModeDwa : ModeBypass;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_count_q <= '0;
            s1_legal_q <= 1'b1;
            s1_mode_q  <= ModeBypass;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_count_q <= s1_count_d;
            s1_legal_q <= s1_legal_d;
            s1_mode_q  <= s1_mode_d;
        end
    end

    // Stage 2 ---------------------------------------------------------------
    logic [N_ELEM-1:0]  mask;
    logic [N_ELEM-1:0]  rotated;
    logic [N_ELEM-1:0]  elem_d,       elem_q;
    logic [PTR_W-1:0]   ptr_d,        ptr_q;
    logic               elem_valid_d, elem_valid_q;
    logic               therm_err_d,  therm_err_q;

    dwa_rotator #(
        .N_ELEM (N_ELEM)
    ) u_rotator (
        .count   (s1_count_q),
        .ptr     (ptr_q),
        .mask    (mask),
        .rotated (rotated)
    );

    always_comb begin
        elem_d       = elem_q;
        ptr_d        = ptr_q;
        elem_valid_d = s1_valid_q;
        therm_err_d  = s1_valid_q & ~s1_legal_q;
        if (s1_valid_q) begin
            unique case (s1_mode_q)
                ModeDwa: begin
                    elem_d = rotated;
                    // count == N_ELEM truncates to 0, leaving ptr unchanged.
                    ptr_d  = ptr_q + PTR_W'(s1_count_q);
                end
                ModeBypass: begin
                    // Parking ptr at 0 makes the next DWA sample restart rotation.
                    elem_d = mask;
                    ptr_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_q       <= '0;
            ptr_q        <= '0;
            elem_valid_q <= 1'b0;
            therm_err_q  <= 1'b0;
        end else begin
            elem_q       <= elem_d;
            ptr_q        <= ptr_d;
            elem_valid_q <= elem_valid_d;
            therm_err_q  <= therm_err_d;
        end
    end

    assign bus.elem_out   = elem_q;
    assign bus.ptr_out    = ptr_q;
    assign bus.elem_valid = elem_valid_q;
    assign bus.therm_err  = therm_err_q;

endmodule

// File: tb/tb_dwa_scrambler.sv
// Self-checking bench for dwa_scrambler (N_ELEM = 8): a table of hand-derived
// back-to-back vectors, a reset-in-flight sequence, and randomized streams
// checked against an arithmetic DWA model plus an element-usage balance check.
module tb_dwa_scrambler;

    localparam int N = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    dwa_scrambler_if #(.N_ELEM(N)) bus ();

    dwa_scrambler #(.N_ELEM(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       valid;
        logic       err;
        logic [7:0] elem;
        logic [2:0] ptr;
    } out_t;

    typedef struct {
        logic       en;
        logic [7:0] code;
        logic [7:0] exp_elem;
        int         exp_ptr;
        logic       exp_err;
    } vec_t;

    // Model state: pointer as plain integer, last element pattern, pending output.
    int         m_ptr;
    logic [7:0] m_elem;
    out_t       pend;
    int         usage[N];
    logic       track_usage = 1'b0;

    task automatic compare(input string name, input out_t want);
        out_t got;
        got = {bus.elem_valid, bus.therm_err, bus.elem_out, bus.ptr_out};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got valid=%0b err=%0b elem=%02h ptr=%0d, expected valid=%0b err=%0b elem=%02h ptr=%0d",
                     name, got.valid, got.err, got.elem, got.ptr,
                     want.valid, want.err, want.elem, want.ptr);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_elem = '0;
        pend   = '0;
        for (int i = 0; i < N; i++) usage[i] = 0;
    endtask

    task automatic predict(input logic v, input logic e, input logic [7:0] code, output out_t o);
        int   cnt;
        logic legal;
        if (!v) begin
            o = {1'b0, 1'b0, m_elem, 3'(m_ptr)};
        end else begin
            cnt   = $countones(code);
            legal = (32'(code) == ((32'd1 << cnt) - 32'd1));
            if (e) begin
                for (int i = 0; i < N; i++) begin
                    m_elem[i] = ((((i - m_ptr) % N) + N) % N) < cnt;
                end
                m_ptr = (m_ptr + cnt) % N;
            end else begin
                m_elem = 8'((32'd1 << cnt) - 32'd1);
                m_ptr  = 0;
            end
            o = {1'b1, ~legal, m_elem, 3'(m_ptr)};
        end
    endtask

    // Drive one cycle of input, then check the output due after this edge.
    task automatic step(input logic v, input logic e, input logic [7:0] code, input string name);
        out_t nxt;
        int   lo, hi;
        bus.therm_valid = v;
        bus.en          = e;
        bus.therm_in    = code;
        predict(v, e, code, nxt);
        @(posedge clk);
        #1;
        compare(name, pend);
        if (track_usage && bus.elem_valid) begin
            lo = 1 << 30;
            hi = 0;
            for (int i = 0; i < N; i++) begin
                usage[i] += int'(bus.elem_out[i]);
                if (usage[i] < lo) lo = usage[i];
                if (usage[i] > hi) hi = usage[i];
            end
            checks++;
            if (hi - lo > 1) begin
                errors++;
                $display("FAIL usage_balance: got spread=%0d (min %0d max %0d), expected spread<=1",
                         hi - lo, lo, hi);
            end
        end
        pend = nxt;
    endtask

    task automatic do_reset(input string name);
        bus.therm_valid = 1'b0;
        bus.en          = 1'b0;
        bus.therm_in    = '0;
        #2;
        rst_n = 1'b0;
        #1;
        compare(name, '0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_reset();
    endtask

    vec_t vecs[$];

    initial begin
        out_t want;
        logic v, e;
        logic [7:0] code;

        bus.therm_valid = 1'b0;
        bus.en          = 1'b0;
        bus.therm_in    = '0;
        model_reset();

        // Hand-derived vectors, applied back to back from reset.
        vecs.push_back('{1'b1, 8'h07, 8'h07, 3, 1'b0});
        vecs.push_back('{1'b1, 8'h0F, 8'h78, 7, 1'b0});
        vecs.push_back('{1'b1, 8'h03, 8'h81, 1, 1'b0});
        vecs.push_back('{1'b1, 8'hFF, 8'hFF, 1, 1'b0});
        vecs.push_back('{1'b1, 8'h00, 8'h00, 1, 1'b0});
        vecs.push_back('{1'b1, 8'h05, 8'h06, 3, 1'b1});
        vecs.push_back('{1'b0, 8'h1F, 8'h1F, 0, 1'b0});
        vecs.push_back('{1'b1, 8'h01, 8'h01, 1, 1'b0});
        vecs.push_back('{1'b1, 8'h0C, 8'h06, 3, 1'b1});
        vecs.push_back('{1'b1, 8'h0E, 8'h38, 6, 1'b1});
        vecs.push_back('{1'b1, 8'h7F, 8'hDF, 5, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 0, 1'b0});
        vecs.push_back('{1'b1, 8'h80, 8'h01, 1, 1'b1});

        do_reset("reset_state");

        for (int i = 0; i <= vecs.size(); i++) begin
            if (i < vecs.size()) begin
                bus.therm_valid = 1'b1;
                bus.en          = vecs[i].en;
                bus.therm_in    = vecs[i].code;
            end else begin
                bus.therm_valid = 1'b0;
                bus.therm_in    = '0;
            end
            @(posedge clk);
            #1;
            if (i == 0) begin
                compare("latency_first_edge", '0);
            end else begin
                want = {1'b1, vecs[i-1].exp_err, vecs[i-1].exp_elem, 3'(vecs[i-1].exp_ptr)};
                compare($sformatf("vec%0d", i - 1), want);
            end
        end
        @(posedge clk);
        #1;
        compare("hold_idle", {1'b0, 1'b0, 8'h01, 3'd1});

        // Reset with samples in flight.
        do_reset("reset_before_inflight");
        step(1'b1, 1'b1, 8'h07, "inflight_a_capture");
        step(1'b1, 1'b1, 8'h0F, "inflight_a_out");
        bus.therm_valid = 1'b1;
        bus.therm_in    = 8'h03;
        @(posedge clk);
        #1;
        compare("inflight_b_out", pend);
        #1;
        rst_n = 1'b0;
        #1;
        compare("async_reset_outputs", '0);
        bus.therm_valid = 1'b0;
        bus.therm_in    = '0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, "post_reset_idle");
        step(1'b1, 1'b1, 8'h03, "post_reset_capture");
        step(1'b0, 1'b1, 8'h00, "post_reset_first");
        step(1'b0, 1'b1, 8'h00, "post_reset_hold");

        // Long legal DWA stream with gaps; usage must stay balanced.
        do_reset("reset_before_stream");
        track_usage = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            v    = ($urandom_range(0, 9) != 0);
            code = 8'((32'd1 << $urandom_range(0, 8)) - 32'd1);
            step(v, 1'b1, code, "rand_dwa");
        end
        step(1'b0, 1'b1, 8'h00, "rand_dwa_flush");
        step(1'b0, 1'b1, 8'h00, "rand_dwa_flush");
        track_usage = 1'b0;

        // Mixed stream: mode toggles and illegal codes.
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 4) != 0);
            e = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0) code = 8'($urandom);
            else                           code = 8'((32'd1 << $urandom_range(0, 8)) - 32'd1);
            step(v, e, code, "rand_mixed");
        end
        step(1'b0, 1'b1, 8'h00, "rand_mixed_flush");
        step(1'b0, 1'b1, 8'h00, "rand_mixed_flush");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
